// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Request/response bundle for the fetch and LSU ports plus the
//               shared memory control lines of mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    // Fetch port
    logic              i_req_valid_i;
    logic              i_req_ready_o;
    logic [AWIDTH-1:0] i_addr_i;
    logic              i_rsp_valid_o;
    logic [DWIDTH-1:0] i_rsp_data_o;
    logic              i_rsp_err_o;
    logic              i_rsp_ready_i;

    // Load/store port
    logic              d_req_valid_i;
    logic              d_req_ready_o;
    logic [AWIDTH-1:0] d_addr_i;
    logic              d_we_i;
    logic [DWIDTH-1:0] d_wdata_i;
    logic [2:0]        d_funct3_i;
    logic              d_rsp_valid_o;
    logic [DWIDTH-1:0] d_rsp_data_o;
    logic              d_rsp_err_o;
    logic              d_rsp_ready_i;

    // Memory side
    logic [AWIDTH-1:0] mem_addr_o;
    logic [DWIDTH-1:0] mem_data_o;
    logic              mem_read_en_o;
    logic              mem_write_en_o;
    logic [2:0]        mem_funct3_o;
    logic [DWIDTH-1:0] mem_data_i;

    // Arbiter view
    modport slave (
        input  i_req_valid_i, i_addr_i, i_rsp_ready_i,
        input  d_req_valid_i, d_addr_i, d_we_i, d_wdata_i, d_funct3_i, d_rsp_ready_i,
        input  mem_data_i,
        output i_req_ready_o, i_rsp_valid_o, i_rsp_data_o, i_rsp_err_o,
        output d_req_ready_o, d_rsp_valid_o, d_rsp_data_o, d_rsp_err_o,
        output mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o, mem_funct3_o
    );

    // Requester / memory view
    modport master (
        output i_req_valid_i, i_addr_i, i_rsp_ready_i,
        output d_req_valid_i, d_addr_i, d_we_i, d_wdata_i, d_funct3_i, d_rsp_ready_i,
        output mem_data_i,
        input  i_req_ready_o, i_rsp_valid_o, i_rsp_data_o, i_rsp_err_o,
        input  d_req_ready_o, d_rsp_valid_o, d_rsp_data_o, d_rsp_err_o,
        input  mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o, mem_funct3_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Arbitrates the single-port unified memory between instruction
//               fetch and the LSU, with a bounded D-port streak and one-cycle
//               registered responses. Optional macro MEM_ARB_ALIGN_CHECK_EN
//               turns misaligned requests into error responses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AWIDTH       = 32,
    parameter int DWIDTH       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    localparam logic [3:0] c_MAX_STREAK  = 4'(MAX_D_STREAK);
    localparam logic [2:0] c_FUNCT3_WORD = 3'b010;

    logic              r_i_rsp_valid;
    logic [DWIDTH-1:0] r_i_rsp_data;
    logic              r_d_rsp_valid;
    logic [DWIDTH-1:0] r_d_rsp_data;
    logic [3:0]        r_d_streak;

    logic w_i_elig;
    logic w_d_elig;
    logic w_grant_i;
    logic w_grant_d;
    logic w_i_mis;
    logic w_d_mis;

    // A port may take a new request only if its response slot is free or draining now.
    assign w_i_elig = bus.i_req_valid_i && (!r_i_rsp_valid || bus.i_rsp_ready_i);
    assign w_d_elig = bus.d_req_valid_i && (!r_d_rsp_valid || bus.d_rsp_ready_i);

    assign w_grant_d = !rst && w_d_elig && (!w_i_elig || (r_d_streak != c_MAX_STREAK));
    assign w_grant_i = !rst && w_i_elig && !w_grant_d;

    assign bus.i_req_ready_o = w_grant_i;
    assign bus.d_req_ready_o = w_grant_d;

`ifdef MEM_ARB_ALIGN_CHECK_EN
    logic r_i_rsp_err;
    logic r_d_rsp_err;

    assign w_i_mis = (bus.i_addr_i[1:0] != 2'b00);

    always_comb begin
        w_d_mis = 1'b0;
        case (bus.d_funct3_i)
            3'b001, 3'b101: w_d_mis = bus.d_addr_i[0];
            3'b010:         w_d_mis = (bus.d_addr_i[1:0] != 2'b00);
            default:        w_d_mis = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i_rsp_err <= 1'b0;
            r_d_rsp_err <= 1'b0;
        end else begin
            if (w_grant_i) begin
                r_i_rsp_err <= w_i_mis;
            end else if (bus.i_rsp_ready_i) begin
                r_i_rsp_err <= 1'b0;
            end
            if (w_grant_d) begin
                r_d_rsp_err <= w_d_mis;
            end else if (bus.d_rsp_ready_i) begin
                r_d_rsp_err <= 1'b0;
            end
        end
    end

    assign bus.i_rsp_err_o = r_i_rsp_err;
    assign bus.d_rsp_err_o = r_d_rsp_err;
`else
    assign w_i_mis         = 1'b0;
    assign w_d_mis         = 1'b0;
    assign bus.i_rsp_err_o = 1'b0;
    assign bus.d_rsp_err_o = 1'b0;
`endif

    // Memory control is only driven for an accepted, well-formed request.
    always_comb begin
        bus.mem_addr_o     = '0;
        bus.mem_data_o     = '0;
        bus.mem_read_en_o  = 1'b0;
        bus.mem_write_en_o = 1'b0;
        bus.mem_funct3_o   = 3'b000;
        if (w_grant_i && !w_i_mis) begin
            bus.mem_addr_o    = bus.i_addr_i;
            bus.mem_read_en_o = 1'b1;
            bus.mem_funct3_o  = c_FUNCT3_WORD;
        end else if (w_grant_d && !w_d_mis) begin
            bus.mem_addr_o   = bus.d_addr_i;
            bus.mem_funct3_o = bus.d_funct3_i;
            if (bus.d_we_i) begin
                bus.mem_write_en_o = 1'b1;
                bus.mem_data_o     = bus.d_wdata_i;
            end else begin
                bus.mem_read_en_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i_rsp_valid <= 1'b0;
            r_i_rsp_data  <= '0;
            r_d_rsp_valid <= 1'b0;
            r_d_rsp_data  <= '0;
        end else begin
            if (w_grant_i) begin
                r_i_rsp_valid <= 1'b1;
                r_i_rsp_data  <= w_i_mis ? '0 : bus.mem_data_i;
            end else if (bus.i_rsp_ready_i) begin
                r_i_rsp_valid <= 1'b0;
            end
            if (w_grant_d) begin
                r_d_rsp_valid <= 1'b1;
                r_d_rsp_data  <= (bus.d_we_i || w_d_mis) ? '0 : bus.mem_data_i;
            end else if (bus.d_rsp_ready_i) begin
                r_d_rsp_valid <= 1'b0;
            end
        end
    end

    // Streak only grows while fetch is actually being held off.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_streak <= 4'd0;
        end else if (!bus.i_req_valid_i || w_grant_i) begin
            r_d_streak <= 4'd0;
        end else if (w_grant_d && (r_d_streak != c_MAX_STREAK)) begin
            r_d_streak <= r_d_streak + 4'd1;
        end
    end

    assign bus.i_rsp_valid_o = r_i_rsp_valid;
    assign bus.i_rsp_data_o  = r_i_rsp_data;
    assign bus.d_rsp_valid_o = r_d_rsp_valid;
    assign bus.d_rsp_data_o  = r_d_rsp_data;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port, byte-addressable unified memory between two requesters: instruction fetch (I-port, read-only word) and load/store unit (D-port, read/write, sized by funct3).
- Memory reads are combinational and writes commit at posedge, so an access completes in the cycle it is accepted; the arbiter registers each port's response.
- Sits between the fetch/LSU stages and the memory instance; owns every memory control signal.

Parameters:
- AWIDTH, 32, address width
- DWIDTH, 32, data width
- MAX_D_STREAK, 4, consecutive D-grants allowed while I-port is waiting before I-port is forced through (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req_valid_i  in  1  fetch request valid
- i_req_ready_o  out  1  fetch request accepted this cycle when high with valid
- i_addr_i  in  AWIDTH  fetch address
- i_rsp_valid_o  out  1  fetch response valid
- i_rsp_data_o  out  DWIDTH  fetched word
- i_rsp_err_o  out  1  fetch error flag (see Optional Feature)
- i_rsp_ready_i  in  1  fetch consumer takes response
- d_req_valid_i  in  1  LSU request valid
- d_req_ready_o  out  1  LSU request accepted
- d_addr_i  in  AWIDTH  LSU byte address
- d_we_i  in  1  1 = store, 0 = load
- d_wdata_i  in  DWIDTH  store data (LSB-aligned)
- d_funct3_i  in  3  RISC-V load/store funct3
- d_rsp_valid_o  out  1  LSU response valid
- d_rsp_data_o  out  DWIDTH  load data (already extended by memory); 0 for stores
- d_rsp_err_o  out  1  LSU error flag
- d_rsp_ready_i  in  1  LSU takes response
- mem_addr_o  out  AWIDTH  to memory addr_i
- mem_data_o  out  DWIDTH  to memory data_i
- mem_read_en_o  out  1  to memory read_en_i
- mem_write_en_o  out  1  to memory write_en_i
- mem_funct3_o  out  3  to memory funct3_i
- mem_data_i  in  DWIDTH  from memory data_o

Behaviour:
- Port X is eligible when X_req_valid_i && (!X_rsp_valid_o || X_rsp_ready_i); the response slot must be free or draining this cycle.
- Grant (combinational): only one eligible port wins. If both are eligible, D wins unless d_streak == MAX_D_STREAK, in which case I wins.
- X_req_ready_o = grant_X. At most one ready is high per cycle. Valid must not depend on ready; ready may depend on valid.
- On accept, memory signals are driven in the same cycle:
  - I-port: addr = i_addr_i, read_en = 1, funct3 = 3'b010.
  - D-port: addr = d_addr_i, funct3 = d_funct3_i; load sets read_en = 1; store sets write_en = 1 and data = d_wdata_i.
- No accept: mem_read_en_o = mem_write_en_o = 0, addr/data/funct3 = 0.
- Response timing: at the posedge after accept, X_rsp_valid_o = 1 and X_rsp_data_o = the mem_data_i sampled that cycle (0 for stores). Latency is 1 cycle.
- Response hold: valid and data hold until X_rsp_ready_i. On handshake with no new accept, valid clears next cycle. Back-to-back accept with handshake in the same cycle reloads the register, giving a throughput of 1 per port per cycle.
- d_streak (4-bit): increments, saturating at MAX_D_STREAK, on a D accept while i_req_valid_i is high and I is not accepted. Clears to 0 on any I accept or any cycle i_req_valid_i is low.
- Both ports blocked by full response slots: no grant, memory idle, streak unchanged.
- Reset values: all rsp_valid = 0, rsp_data = 0, rsp_err = 0, d_streak = 0, all ready = 0, mem_read_en_o = mem_write_en_o = 0.
- Reset mid-operation: pending responses are discarded, no write is issued in any cycle where rst = 1, and arbitration resumes the cycle after rst falls.
- Errors: rsp_err_o is 0 whenever the optional feature is absent. Out-of-range addresses are not checked here; the memory returns its own sentinel data.

Optional Feature:
- Macro: MEM_ARB_ALIGN_CHECK_EN
- Defined:
  - A misaligned request is still accepted through normal arbitration. Misaligned means: I-port addr[1:0] != 0; D halfword funct3 (001/101) with addr[0] = 1; D word funct3 (010) with addr[1:0] != 0.
  - No memory enable is asserted for it.
  - Next cycle, rsp_valid = 1, rsp_err = 1, rsp_data = 0.
  - It counts toward d_streak like a normal D accept.
- Undefined: no alignment check; rsp_err_o tied to 0; the misaligned access goes to memory unchanged.

Test Plan:
- I-only: fetch 0x01000000 with rsp_ready = 1 each cycle, memory word 0x00500093 -> i_req_ready high same cycle; i_rsp_valid and data 0x00500093 next cycle; one fetch per cycle sustained.
- D store then load: SW 0xDEADBEEF to 0x01000100, then LB same address -> mem_write_en one cycle; load response data 0xFFFFFFEF; store response data 0.
- Contention: I and D valid continuously, MAX_D_STREAK = 4 -> grant pattern D,D,D,D,I repeating; no cycle with both ready high.
- Backpressure: d_rsp_ready = 0 for 3 cycles with D valid -> d_req_ready low and memory not driven for D; I still granted; D data held stable until ready rises.
- Reset mid-flight: rst asserted the cycle a SW is accepted -> mem_write_en_o = 0 that cycle; all rsp_valid = 0 next cycle; memory contents unchanged.
- MEM_ARB_ALIGN_CHECK_EN: LW at 0x01000002 -> no mem enable; d_rsp_err = 1, data 0 next cycle. Without the macro, the memory is read and err = 0.
